bvh_leaf_prim_sequencer: RTL and testbench
==========================================

# bvh_leaf_prim_sequencer

Sequential front end for the closest-hit / any-hit ray unit. It accepts a BVH leaf descriptor (base index, primitive count) and a ray, then reads the leaf's primitives from primitive memory one per cycle. It packs them into groups of `BVH_AABB_TEST_UNIT_SIZE`, presents each group to the combinational ray unit, and folds the per-group results into a running closest hit. For shadow rays it exits early on the first hit. It sits between the BVH traversal controller (the issuer of leaf jobs) and the ray unit (the consumer of the primitive group).

## Interface
- UNIT_SIZE, default `BVH_AABB_TEST_UNIT_SIZE` (4): primitives per group presented to the ray unit.
- PRIM_ADDR_W, default 10: primitive memory address width.
- COUNT_W, default 8: leaf primitive count width.

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_valid  in  1  leaf job offered.
- start_ready  out  1  high only in IDLE.
- leaf_base  in  PRIM_ADDR_W  index of the first primitive.
- leaf_count  in  COUNT_W  number of primitives; 0 is legal.
- any_hit_mode  in  1  1 = shadow/any-hit job with early exit.
- ray_in  in  Ray  ray; latched on start accept.
- mem_rd_en  out  1  primitive read strobe.
- mem_rd_addr  out  PRIM_ADDR_W  read address; data returns exactly 1 cycle later.
- mem_rd_data  in  BVH_Primitive  read data.
- ru_ray  out  Ray  latched ray, driven to the ray unit.
- ru_prim  out  BVH_Primitive[UNIT_SIZE]  primitive group, driven to the ray unit.
- ru_hit_data  in  HitData  closest-hit result from the ray unit (combinational).
- ru_any_hit  in  1  any-hit result from the ray unit (combinational).
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_hit_data  out  HitData  final closest hit.
- result_any_hit  out  1  final any-hit flag.

## Operation
- States:
  - IDLE → FETCH on the start handshake (or → DONE if leaf_count == 0).
  - FETCH → WAIT after the last read of the group.
  - WAIT → TEST.
  - TEST → FETCH if primitives remain and no early exit; otherwise → DONE.
  - DONE → IDLE on result_ready.
- On accept: latch ray_in, any_hit_mode, next address = leaf_base, remaining = leaf_count. Set best.bHit = 0, best.T = FixedInf(), and clear the any flag.
- Group size n_g = min(UNIT_SIZE, remaining).
- FETCH lasts n_g cycles. In cycle j: mem_rd_en = 1, mem_rd_addr = next address + j.
- Read data is captured into slot j one cycle later: during FETCH for j ≥ 1, and during WAIT for the last slot.
- In WAIT, slots n_g..UNIT_SIZE-1 are filled with a copy of slot 0. Duplicates cannot change either the closest-hit or the any-hit outcome.
- In TEST, ru_prim is stable and the ray unit outputs are sampled at the end of the cycle:
  - best updates when ru_hit_data.bHit && (!best.bHit || ru_hit_data.T < best.T), using the codebase's Fixed compare.
  - The comparison is strict, so the earlier group wins ties.
  - The any flag is ORed with ru_any_hit.
  - remaining −= n_g; next address += n_g, wrapping modulo 2^PRIM_ADDR_W.
- Early exit: if any_hit_mode and (flag | ru_any_hit), TEST goes to DONE regardless of remaining.
- DONE outputs:
  - result_hit_data = best.
  - result_any_hit = flag (in closest mode this equals best.bHit).
  - Outputs are held stable until result_ready.
- mem_rd_en is 0 in every state except FETCH.

## Timing
- The start handshake completes in cycle 0; FETCH starts in cycle 1.
- Each group takes n_g + 2 cycles. result_valid rises in the cycle after the final TEST.
- leaf_count = 0: result_valid in cycle 1, with bHit = 0 and T = FixedInf().
- start_ready returns in the cycle after the DONE handshake, giving 1 idle cycle between jobs.
- Reset values:
  - state = IDLE.
  - start_ready = 1.
  - result_valid, mem_rd_en, result_any_hit = 0.
  - mem_rd_addr = 0.
  - ru_prim, ru_ray, result_hit_data = all-zero.
- Asserting reset mid-job aborts it immediately. No result is produced and no reads are issued after reset.
- start_valid is ignored outside IDLE.
- result_ready asserted outside DONE has no effect.

## Test plan
- leaf_count = 0, base = 5 → no reads; result_valid at cycle 1; bHit = 0; T = FixedInf().
- count = 3, base = 100, stub T = {7, 3, 9} → reads at addresses 100–102 in cycles 1–3; slot 3 equals slot 0; result_valid at cycle 6; T = 3.
- count = 9, base = 1020 (PRIM_ADDR_W = 10) → addresses 1020..1023 then wrap to 0..4; groups of 4/4/1; result_valid at cycle 16. Cover both a closest hit in the last group and an equal-T tie between groups 0 and 1 (group 0 must win).
- any_hit_mode = 1, count = 12, hit only in group 1 → exit after the second TEST; result_valid at cycle 13; result_any_hit = 1; addresses for group 2 are never issued.
- Result backpressure: hold result_ready low for 5 cycles → result held stable and start_ready = 0 throughout; IDLE is reached 1 cycle after the handshake.
- Assert reset in FETCH cycle 2 → mem_rd_en is low immediately; state = IDLE; a new job then completes with correct results.

Source files
------------

// File: rtl/bvh_leaf_prim_sequencer.sv
// BVH leaf primitive sequencer: fetches a leaf's primitives into fixed-size groups,
// drives them to the combinational ray unit and folds the per-group results.
package bvh_leaf_prim_sequencer_pkg;
    localparam int BVH_AABB_TEST_UNIT_SIZE = 4;

    typedef logic signed [31:0] Fixed;
    localparam Fixed FIXED_INF = 32'sh7fff_ffff;

    function automatic Fixed FixedInf();
        return FIXED_INF;
    endfunction

    function automatic logic FixedLt(input Fixed a, input Fixed b);
        return a < b;
    endfunction

    typedef struct packed {
        Fixed ox;
        Fixed oy;
        Fixed oz;
        Fixed dx;
        Fixed dy;
        Fixed dz;
    } Ray;

    typedef struct packed {
        logic [15:0] prim_id;
        Fixed        v0;
        Fixed        v1;
        Fixed        v2;
    } BVH_Primitive;

    typedef struct packed {
        logic        bHit;
        Fixed        T;
        logic [15:0] prim_id;
    } HitData;
endpackage

module bvh_leaf_prim_sequencer
    import bvh_leaf_prim_sequencer_pkg::*;
#(
    parameter int UNIT_SIZE   = BVH_AABB_TEST_UNIT_SIZE,
    parameter int PRIM_ADDR_W = 10,
    parameter int COUNT_W     = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_valid,
    output logic                              start_ready,
    input  logic [PRIM_ADDR_W-1:0]            leaf_base,
    input  logic [COUNT_W-1:0]                leaf_count,
    input  logic                              any_hit_mode,
    input  Ray                                ray_in,
    output logic                              mem_rd_en,
    output logic [PRIM_ADDR_W-1:0]            mem_rd_addr,
    input  BVH_Primitive                      mem_rd_data,
    output Ray                                ru_ray,
    output BVH_Primitive [UNIT_SIZE-1:0]      ru_prim,
    input  HitData                            ru_hit_data,
    input  logic                              ru_any_hit,
    output logic                              result_valid,
    input  logic                              result_ready,
    output HitData                            result_hit_data,
    output logic                              result_any_hit
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_TEST, S_DONE} state_t;

    localparam HitData NO_HIT = '{bHit: 1'b0, T: FIXED_INF, prim_id: 16'd0};

    function automatic logic [COUNT_W-1:0] group_size(input logic [COUNT_W-1:0] rem);
        if (rem > COUNT_W'(UNIT_SIZE)) return COUNT_W'(UNIT_SIZE);
        return rem;
    endfunction

    // Strict compare: on equal T the hit already held (earlier group) is kept.
    function automatic logic closer(input HitData cand, input HitData cur);
        return cand.bHit && (!cur.bHit || FixedLt(cand.T, cur.T));
    endfunction

    state_t                       state_q, state_d;
    logic                         start_ready_q, start_ready_d;
    logic                         mem_rd_en_q, mem_rd_en_d;
    logic [PRIM_ADDR_W-1:0]       mem_rd_addr_q, mem_rd_addr_d;
    logic [PRIM_ADDR_W-1:0]       next_addr_q, next_addr_d;
    logic [COUNT_W-1:0]           remain_q, remain_d;
    logic [COUNT_W-1:0]           group_n_q, group_n_d;
    logic [COUNT_W-1:0]           fetch_idx_q, fetch_idx_d;
    logic                         any_mode_q, any_mode_d;
    logic                         flag_q, flag_d;
    HitData                       best_q, best_d;
    Ray                           ray_q, ray_d;
    BVH_Primitive [UNIT_SIZE-1:0] prim_q, prim_d;
    logic                         res_valid_q, res_valid_d;
    HitData                       res_hit_q, res_hit_d;
    logic                         res_any_q, res_any_d;
    logic [COUNT_W-1:0]           remain_after;

    always_comb begin
        state_d       = state_q;
        start_ready_d = start_ready_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_rd_addr_d = mem_rd_addr_q;
        next_addr_d   = next_addr_q;
        remain_d      = remain_q;
        group_n_d     = group_n_q;
        fetch_idx_d   = fetch_idx_q;
        any_mode_d    = any_mode_q;
        flag_d        = flag_q;
        best_d        = best_q;
        ray_d         = ray_q;
        prim_d        = prim_q;
        res_valid_d   = res_valid_q;
        res_hit_d     = res_hit_q;
        res_any_d     = res_any_q;
        remain_after  = remain_q - group_n_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid && start_ready_q) begin
                    ray_d         = ray_in;
                    any_mode_d    = any_hit_mode;
                    next_addr_d   = leaf_base;
                    remain_d      = leaf_count;
                    best_d        = NO_HIT;
                    flag_d        = 1'b0;
                    start_ready_d = 1'b0;
                    if (leaf_count == '0) begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                        res_hit_d   = NO_HIT;
                        res_any_d   = 1'b0;
                    end else begin
                        state_d       = S_FETCH;
                        group_n_d     = group_size(leaf_count);
                        fetch_idx_d   = '0;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = leaf_base;
                    end
                end
            end
            S_FETCH: begin
                // Data for read j-1 arrives while read j is being issued.
                for (int i = 0; i < UNIT_SIZE; i++) begin
                    if (fetch_idx_q != '0 && COUNT_W'(i) == fetch_idx_q - COUNT_W'(1))
                        prim_d[i] = mem_rd_data;
                end
                fetch_idx_d = fetch_idx_q + COUNT_W'(1);
                if (fetch_idx_q == group_n_q - COUNT_W'(1)) begin
                    state_d     = S_WAIT;
                    mem_rd_en_d = 1'b0;
                end else begin
                    mem_rd_addr_d = mem_rd_addr_q + PRIM_ADDR_W'(1);
                end
            end
            S_WAIT: begin
                // Pad unused slots with slot 0; for a one-primitive group slot 0 is arriving now.
                for (int i = 0; i < UNIT_SIZE; i++) begin
                    if (COUNT_W'(i) == group_n_q - COUNT_W'(1))
                        prim_d[i] = mem_rd_data;
                    else if (COUNT_W'(i) >= group_n_q)
                        prim_d[i] = (group_n_q == COUNT_W'(1)) ? mem_rd_data : prim_q[0];
                end
                state_d = S_TEST;
            end
            S_TEST: begin
                if (closer(ru_hit_data, best_q))
                    best_d = ru_hit_data;
                flag_d      = flag_q | ru_any_hit;
                remain_d    = remain_after;
                next_addr_d = next_addr_q + PRIM_ADDR_W'(group_n_q);
                if ((any_mode_q && flag_d) || remain_after == '0) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_hit_d   = best_d;
                    res_any_d   = flag_d;
                end else begin
                    state_d       = S_FETCH;
                    group_n_d     = group_size(remain_after);
                    fetch_idx_d   = '0;
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = next_addr_q + PRIM_ADDR_W'(group_n_q);
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d       = S_IDLE;
                    res_valid_d   = 1'b0;
                    start_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_ready_q <= 1'b1;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            next_addr_q   <= '0;
            remain_q      <= '0;
            group_n_q     <= '0;
            fetch_idx_q   <= '0;
            any_mode_q    <= 1'b0;
            flag_q        <= 1'b0;
            best_q        <= '0;
            ray_q         <= '0;
            prim_q        <= '0;
            res_valid_q   <= 1'b0;
            res_hit_q     <= '0;
            res_any_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_ready_q <= start_ready_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            next_addr_q   <= next_addr_d;
            remain_q      <= remain_d;
            group_n_q     <= group_n_d;
            fetch_idx_q   <= fetch_idx_d;
            any_mode_q    <= any_mode_d;
            flag_q        <= flag_d;
            best_q        <= best_d;
            ray_q         <= ray_d;
            prim_q        <= prim_d;
            res_valid_q   <= res_valid_d;
            res_hit_q     <= res_hit_d;
            res_any_q     <= res_any_d;
        end
    end

    assign start_ready     = start_ready_q;
    assign mem_rd_en       = mem_rd_en_q;
    assign mem_rd_addr     = mem_rd_addr_q;
    assign ru_ray          = ray_q;
    assign ru_prim         = prim_q;
    assign result_valid    = res_valid_q;
    assign result_hit_data = res_hit_q;
    assign result_any_hit  = res_any_q;
endmodule

// File: tb/tb_bvh_leaf_prim_sequencer.sv
// Directed bench for bvh_leaf_prim_sequencer with a group-level reference model,
// a one-cycle-latency primitive memory and a stub ray unit.
module tb_bvh_leaf_prim_sequencer;
    import bvh_leaf_prim_sequencer_pkg::*;

    localparam int U  = 4;
    localparam int AW = 10;
    localparam int CW = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start_valid;
    logic                 start_ready;
    logic [AW-1:0]        leaf_base;
    logic [CW-1:0]        leaf_count;
    logic                 any_hit_mode;
    Ray                   ray_in;
    logic                 mem_rd_en;
    logic [AW-1:0]        mem_rd_addr;
    BVH_Primitive         mem_rd_data;
    Ray                   ru_ray;
    BVH_Primitive [U-1:0] ru_prim;
    HitData               ru_hit_data;
    logic                 ru_any_hit;
    logic                 result_valid;
    logic                 result_ready;
    HitData               result_hit_data;
    logic                 result_any_hit;

    always #5 clk = ~clk;

    bvh_leaf_prim_sequencer #(.UNIT_SIZE(U), .PRIM_ADDR_W(AW), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .leaf_base(leaf_base), .leaf_count(leaf_count), .any_hit_mode(any_hit_mode),
        .ray_in(ray_in),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .ru_ray(ru_ray), .ru_prim(ru_prim), .ru_hit_data(ru_hit_data), .ru_any_hit(ru_any_hit),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_hit_data(result_hit_data), .result_any_hit(result_any_hit)
    );

    BVH_Primitive mem [1024];

    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Stub ray unit: a primitive hits when v1 != 0, at distance v0; first slot wins ties.
    always_comb begin
        ru_hit_data = '{bHit: 1'b0, T: FixedInf(), prim_id: 16'd0};
        ru_any_hit  = 1'b0;
        for (int s = 0; s < U; s++) begin
            if (ru_prim[s].v1 != 0) begin
                ru_any_hit = 1'b1;
                if (!ru_hit_data.bHit || ru_prim[s].v0 < ru_hit_data.T)
                    ru_hit_data = '{bHit: 1'b1, T: ru_prim[s].v0, prim_id: ru_prim[s].prim_id};
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int cur_cyc = 0;

    bit           exp_en   [64];
    logic [AW-1:0] exp_addr [64];
    bit           exp_test [64];
    BVH_Primitive exp_prim [64][U];
    int           exp_done;
    HitData       exp_hit;
    logic         exp_any;
    Ray           job_ray;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cur_cyc, act, exp);
        end
    endtask

    task automatic sethit(input int a, input int t);
        mem[a].v1 = 32'sd1;
        mem[a].v0 = Fixed'(t);
    endtask

    // Reference: walk the leaf group by group; the overall winner is the earliest primitive with smallest T.
    task automatic model(input int base, input int count, input bit mode);
        int c, off, rem, ng, tc, a;
        bit flag;
        HitData best;
        for (int i = 0; i < 64; i++) begin
            exp_en[i] = 1'b0; exp_test[i] = 1'b0; exp_addr[i] = '0;
        end
        best = '{bHit: 1'b0, T: FixedInf(), prim_id: 16'd0};
        flag = 1'b0; c = 1; off = 0; rem = count;
        while (rem > 0) begin
            ng = (rem < U) ? rem : U;
            for (int j = 0; j < ng; j++) begin
                exp_en[c+j]   = 1'b1;
                exp_addr[c+j] = AW'((base + off + j) % 1024);
            end
            tc = c + ng + 1;
            exp_test[tc] = 1'b1;
            for (int s = 0; s < U; s++) begin
                a = (base + off + ((s < ng) ? s : 0)) % 1024;
                exp_prim[tc][s] = mem[a];
            end
            for (int s = 0; s < ng; s++) begin
                a = (base + off + s) % 1024;
                if (mem[a].v1 != 0) begin
                    flag = 1'b1;
                    if (!best.bHit || mem[a].v0 < best.T)
                        best = '{bHit: 1'b1, T: mem[a].v0, prim_id: mem[a].prim_id};
                end
            end
            c += ng + 2; off += ng; rem -= ng;
            if (mode && flag) break;
        end
        exp_done = c; exp_hit = best; exp_any = flag;
    endtask

    task automatic run_job(input int base, input int count, input bit mode, input int delay,
                           input bit noisy, input int abort_cyc, input int lit_done,
                           input bit lit_hit, input int lit_t, input int lit_id, input bit lit_any);
        int h;
        model(base, count, mode);
        cur_cyc = 0;
        chk("model_latency", 32'(exp_done), 32'(lit_done));
        h = exp_done + delay;
        job_ray = Ray'({6{32'h0A00_0000 + 32'(base)}});
        for (int cyc = 0; cyc <= h + 1 && cyc < 64; cyc++) begin
            cur_cyc      = cyc;
            start_valid  = (cyc == 0) || (noisy && cyc <= h);
            leaf_base    = (cyc == 0) ? AW'(base) : AW'(base + 7);
            leaf_count   = (cyc == 0) ? CW'(count) : CW'(count + 3);
            any_hit_mode = (cyc == 0) ? mode : !mode;
            ray_in       = (cyc == 0) ? job_ray : Ray'(~job_ray);
            result_ready = (cyc == h) || (noisy && cyc >= 1 && cyc < exp_done);
            if (cyc == abort_cyc) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_rd_en", mem_rd_en, 1'b0);
                chk("abort_start_ready", start_ready, 1'b1);
                chk("abort_valid", result_valid, 1'b0);
                @(posedge clk); #1;
                reset = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    cur_cyc = cyc + k;
                    @(negedge clk);
                    chk("post_abort_rd_en", mem_rd_en, 1'b0);
                    chk("post_abort_valid", result_valid, 1'b0);
                    chk("post_abort_start_ready", start_ready, 1'b1);
                    @(posedge clk); #1;
                end
                return;
            end
            @(negedge clk);
            chk("rd_en", mem_rd_en, exp_en[cyc]);
            if (exp_en[cyc]) chk("rd_addr", mem_rd_addr, exp_addr[cyc]);
            chk("start_ready", start_ready, (cyc == 0) || (cyc == h + 1));
            chk("result_valid", result_valid, (cyc >= exp_done) && (cyc <= h));
            if (cyc >= exp_done && cyc <= h) begin
                chk("result_hit_data", result_hit_data, exp_hit);
                chk("result_any_hit", result_any_hit, exp_any);
            end
            if (exp_test[cyc]) begin
                for (int s = 0; s < U; s++) chk("ru_prim", ru_prim[s], exp_prim[cyc][s]);
                chk("ru_ray", ru_ray, job_ray);
            end
            if (cyc == lit_done) begin
                chk("lit_valid", result_valid, 1'b1);
                chk("lit_bhit", result_hit_data.bHit, lit_hit);
                chk("lit_t", result_hit_data.T, 32'(lit_t));
                chk("lit_id", result_hit_data.prim_id, 16'(lit_id));
                chk("lit_any", result_any_hit, lit_any);
            end
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        result_ready = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++)
            mem[a] = '{prim_id: 16'(a), v0: 32'sd1000, v1: 32'sd0, v2: 32'sd0};
        reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
        leaf_base = '0; leaf_count = '0; any_hit_mode = 1'b0; ray_in = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_rd_addr", mem_rd_addr, '0);
        chk("rst_any_hit", result_any_hit, 1'b0);
        chk("rst_ru_prim", ru_prim, '0);
        chk("rst_ru_ray", ru_ray, '0);
        chk("rst_hit_data", result_hit_data, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Empty leaf: result next cycle, no hit at infinity.
        run_job(5, 0, 1'b0, 0, 1'b0, -1, 1, 1'b0, 32'h7fff_ffff, 0, 1'b0);

        sethit(100, 7); sethit(101, 3); sethit(102, 9);
        run_job(100, 3, 1'b0, 0, 1'b0, -1, 6, 1'b1, 3, 101, 1'b1);

        // Wrapping leaf: closest hit lives in the single-primitive last group.
        sethit(1021, 5); sethit(1023, 30); sethit(1, 5); sethit(4, 2);
        run_job(1020, 9, 1'b0, 0, 1'b0, -1, 16, 1'b1, 2, 4, 1'b1);

        // Same leaf without the last-group hit: equal T in groups 0 and 1, group 0 wins.
        mem[4].v1 = 32'sd0;
        run_job(1020, 9, 1'b0, 0, 1'b1, -1, 16, 1'b1, 5, 1021, 1'b1);

        sethit(205, 8); sethit(209, 1);
        run_job(200, 12, 1'b1, 0, 1'b0, -1, 13, 1'b1, 8, 205, 1'b1);
        run_job(200, 12, 1'b0, 0, 1'b0, -1, 19, 1'b1, 1, 209, 1'b1);

        // Backpressured result.
        run_job(100, 3, 1'b0, 5, 1'b0, -1, 6, 1'b1, 3, 101, 1'b1);

        // Reset during the second fetch cycle, then a clean job.
        run_job(1020, 9, 1'b0, 0, 1'b0, 2, 16, 1'b1, 5, 1021, 1'b1);
        run_job(100, 3, 1'b0, 0, 1'b0, -1, 6, 1'b1, 3, 101, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
